// File: rtl/ncl_mult3_sink_if.sv
// ncl_mult3_sink_if: dual-rail product rails in, Ki and valid/ready product out.
// With NCL_SINK_ILLEGAL_CHK_EN defined the interface also carries illegal_err.
interface ncl_mult3_sink_if;
    logic [5:0] po_rail1;
    logic [5:0] po_rail0;
    logic       ki;
    logic [5:0] prod;
    logic       prod_valid;
    logic       prod_ready;
    logic       timeout;
`ifdef NCL_SINK_ILLEGAL_CHK_EN
    logic       illegal_err;
    modport master (
        input  po_rail1, po_rail0, prod_ready,
        output ki, prod, prod_valid, timeout, illegal_err
    );
    modport slave (
        output po_rail1, po_rail0, prod_ready,
        input  ki, prod, prod_valid, timeout, illegal_err
    );
`else
    modport master (
        input  po_rail1, po_rail0, prod_ready,
        output ki, prod, prod_valid, timeout
    );
    modport slave (
        output po_rail1, po_rail0, prod_ready,
        input  ki, prod, prod_valid, timeout
    );
`endif
endinterface

// File: rtl/ncl_mult3_sink.sv
// ncl_mult3_sink: clocked sink for the 3x3 NCL multiplier; runs the NULL/DATA handshake and
// turns each stable DATA wavefront into a 6-bit product on a valid/ready port.
// Optional feature: define NCL_SINK_ILLEGAL_CHK_EN to flag bits with both rails high (illegal_err).
module ncl_mult3_sink #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    ncl_mult3_sink_if.master bus
);
    typedef enum logic [1:0] {REQ_NULL, REQ_DATA, HOLD} state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CYC);

    logic [11:0] r_sync [SYNC_STAGES];
    logic [11:0] r_prev_s;
    logic [11:0] w_s;
    logic [5:0]  w_r1;
    logic [5:0]  w_r0;
    logic        w_complete;
    logic        w_null;
    logic        w_same;
    logic        w_cond;
    logic        w_stable;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_release;
    logic        r_ki;
    logic        r_valid;
    logic [5:0]  r_prod;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_r1       = w_s[11:6];
    assign w_r0       = w_s[5:0];
    // A bit with both rails high is never counted as complete.
    assign w_complete = &(w_r1 ^ w_r0);
    assign w_null     = ~|w_s;
    assign w_same     = (w_s == r_prev_s);
    // HOLD tracks NULL so a released product can go straight back to REQ_DATA.
    assign w_cond     = (r_state == REQ_DATA) ? w_complete : w_null;
    assign w_cnt_nxt  = !w_cond ? 4'd0 : !w_same ? 4'd1 : (r_cnt == STABLE) ? STABLE : r_cnt + 4'd1;
    assign w_stable   = (w_cnt_nxt == STABLE);

    // Synchronize all twelve rails and remember the previous synchronized word.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            r_prev_s <= '0;
        end else begin
            r_sync[0] <= {bus.po_rail1, bus.po_rail0};
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_prev_s <= w_s;
        end

    // Count consecutive identical samples meeting the current state's target condition.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_cnt <= 4'd0;
        else r_cnt <= w_cnt_nxt;

    // Handshake FSM next state; capture and release strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            REQ_NULL: w_state_nxt = (w_stable && w_null) ? REQ_DATA : REQ_NULL;
            REQ_DATA: begin
                w_accept    = w_stable && w_complete;
                w_state_nxt = w_accept ? HOLD : REQ_DATA;
            end
            HOLD: begin
                w_release   = bus.prod_ready;
                w_state_nxt = !w_release ? HOLD : (w_stable && w_null) ? REQ_DATA : REQ_NULL;
            end
            default: w_state_nxt = REQ_NULL;
        endcase
    end

    // State, registered Ki (glitch-free towards the asynchronous multiplier) and the product holding register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= REQ_NULL;
            r_ki    <= 1'b0;
            r_valid <= 1'b0;
            r_prod  <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ki    <= (w_state_nxt == REQ_DATA);
            if (w_accept) r_prod <= w_r1;
            r_valid <= w_accept ? 1'b1 : w_release ? 1'b0 : r_valid;
        end

    assign bus.ki         = r_ki;
    assign bus.prod       = r_prod;
    assign bus.prod_valid = r_valid;

    generate
        if (TIMEOUT_CYC > 0) begin : g_wd
            localparam int WDW = $clog2(TIMEOUT_CYC + 1);
            localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYC);
            logic [WDW-1:0] r_wd;
            logic [WDW-1:0] w_wd_nxt;
            logic           r_timeout;
            // Backpressure in HOLD is legal, so only the two request states age the watchdog.
            assign w_wd_nxt = (w_state_nxt != r_state) ? '0 :
                              (r_state == HOLD || r_wd == WD_MAX) ? r_wd : r_wd + WDW'(1);
            // Watchdog counter and sticky timeout flag; the FSM is never forced.
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    r_wd      <= '0;
                    r_timeout <= 1'b0;
                end else begin
                    r_wd      <= w_wd_nxt;
                    r_timeout <= r_timeout | (w_wd_nxt == WD_MAX);
                end
            assign bus.timeout = r_timeout;
        end else begin : g_no_wd
            assign bus.timeout = 1'b0;
        end
    endgenerate

`ifdef NCL_SINK_ILLEGAL_CHK_EN
    logic [5:0]      w_both;
    logic [5:0][3:0] r_ill_cnt;
    logic [5:0][3:0] w_ill_nxt;
    logic            w_ill_hit;
    logic            r_illegal;

    assign w_both = w_r1 & w_r0;

    // Per-bit run length of both-rails-high while a request is outstanding.
    always_comb begin
        w_ill_hit = 1'b0;
        w_ill_nxt = '0;
        for (int k = 0; k < 6; k++) begin
            w_ill_nxt[k] = (w_both[k] && r_state != HOLD) ?
                           ((r_ill_cnt[k] == STABLE) ? STABLE : r_ill_cnt[k] + 4'd1) : 4'd0;
            w_ill_hit    = w_ill_hit | (w_ill_nxt[k] == STABLE);
        end
    end

    // Run-length registers and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_ill_cnt <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_ill_cnt <= w_ill_nxt;
            r_illegal <= r_illegal | w_ill_hit;
        end

    assign bus.illegal_err = r_illegal;
`endif
endmodule

// File: tb/tb_ncl_mult3_sink.sv
// tb_ncl_mult3_sink: randomized scoreboard bench for ncl_mult3_sink (3x3 products a*b pushed on issue, popped by a monitor).
module tb_ncl_mult3_sink;
    localparam int SYNC = 2;
    localparam int STAB = 2;
    localparam int TMO  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    bit         rdy_rand = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] exp_q [$];

    ncl_mult3_sink_if bus();

    ncl_mult3_sink #(.SYNC_STAGES(SYNC), .STABLE_CYC(STAB), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_ki(input logic v, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ki !== v && n < budget);
        chk("ki_wait", int'(bus.ki), int'(v));
    endtask

    task automatic drive_null();
        bus.po_rail1 = 6'd0;
        bus.po_rail0 = 6'd0;
    endtask

    task automatic drive_prod(input logic [5:0] p, input bit skew);
        int ord [6];
        int j;
        int t;
        if (!skew) begin
            bus.po_rail1 = p;
            bus.po_rail0 = ~p;
        end else begin
            for (int k = 0; k < 6; k++) ord[k] = k;
            for (int k = 5; k > 0; k--) begin
                j = int'($urandom_range(0, k));
                t = ord[k];
                ord[k] = ord[j];
                ord[j] = t;
            end
            for (int k = 0; k < 6; k++) begin
                bus.po_rail1[ord[k]] = p[ord[k]];
                bus.po_rail0[ord[k]] = ~p[ord[k]];
                if (k < 5) @(negedge clk);
            end
        end
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 bus.prod_ready = r;
    endtask

    task automatic xact(input logic [5:0] p, input bit skew, input int dly);
        int n;
        wait_ki(1'b1, 300, n);
        repeat (dly) @(negedge clk);
        exp_q.push_back(p);
        drive_prod(p, skew);
        wait_ki(1'b0, 60, n);
        repeat (dly) @(negedge clk);
        drive_null();
    endtask

    // Monitor: every presented product must match the scoreboard head; ki must be low while a product is held.
    always @(negedge clk)
        if (rst_n && bus.prod_valid) begin
            chk("ki_low_while_valid", int'(bus.ki), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_prod: got %0d, required no product", bus.prod);
            end else begin
                chk("prod", int'(bus.prod), int'(exp_q[0]));
                if (bus.prod_ready) void'(exp_q.pop_front());
            end
        end

    // Random consumer backpressure, changed just after the active edge.
    initial forever begin
        @(posedge clk);
        #1 if (rdy_rand) bus.prod_ready = ($urandom_range(0, 3) != 0);
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        logic [5:0] p;
        bus.prod_ready = 1'b1;
        drive_null();
        repeat (4) begin
            @(negedge clk);
            bus.po_rail1 = 6'($urandom);
            bus.po_rail0 = 6'($urandom);
        end
        chk("rst_ki", int'(bus.ki), 0);
        chk("rst_valid", int'(bus.prod_valid), 0);
        chk("rst_prod", int'(bus.prod), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
`ifdef NCL_SINK_ILLEGAL_CHK_EN
        chk("rst_illegal", int'(bus.illegal_err), 0);
`endif
        drive_null();
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_ki(1'b1, SYNC + STAB + 2, n);
        exp_q.push_back(6'd35);
        drive_prod(6'd35, 1'b0);
        wait_ki(1'b0, 20, n);
        chk("capture_latency_ok", int'(n <= SYNC + STAB + 2), 1);
        drive_null();
        wait_ki(1'b1, 20, n);
        set_ready(1'b0);
        @(negedge clk);
        exp_q.push_back(6'd49);
        drive_prod(6'd49, 1'b0);
        wait_ki(1'b0, 20, n);
        drive_null();
        repeat (20) begin
            @(negedge clk);
            chk("ki_held_low", int'(bus.ki), 0);
        end
        chk("valid_held", int'(bus.prod_valid), 1);
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("ki_after_ready", int'(bus.ki), 1);
        exp_q.push_back(6'd6);
        drive_prod(6'd6, 1'b1);
        wait_ki(1'b0, 30, n);
        drive_null();
`ifdef NCL_SINK_ILLEGAL_CHK_EN
        wait_ki(1'b1, 30, n);
        bus.po_rail1 = 6'd4;
        bus.po_rail0 = 6'h3f;
        repeat (6) @(negedge clk);
        chk("illegal_set", int'(bus.illegal_err), 1);
        chk("illegal_no_capture", int'(bus.prod_valid), 0);
        exp_q.push_back(6'd4);
        bus.po_rail0 = ~6'd4;
        wait_ki(1'b0, 30, n);
        chk("illegal_sticky", int'(bus.illegal_err), 1);
        drive_null();
`endif
        rdy_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            p = 6'($urandom_range(0, 7) * $urandom_range(0, 7));
            xact(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
        rdy_rand = 1'b0;
        set_ready(1'b1);
        chk("timeout_clear", int'(bus.timeout), 0);
        wait_ki(1'b1, 300, n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.timeout && n < 40);
        chk("timeout_cycle", n, TMO);
        chk("timeout_no_capture", int'(bus.prod_valid), 0);
        exp_q.push_back(6'd0);
        drive_prod(6'd0, 1'b0);
        wait_ki(1'b0, 30, n);
        chk("timeout_sticky", int'(bus.timeout), 1);
        drive_null();
        wait_ki(1'b1, 30, n);
        chk("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
